// File: rtl/reg_wr_arbiter.sv
// Four-requester round-robin arbiter feeding one registered register-file write port.
// Optional REG_WR_ARB_ZERO_PROTECT_EN: accepted writes to address 0 are swallowed, never presented.
module reg_wr_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            req_valid,
    input  logic [4*ADDR_W-1:0]   req_addr,
    input  logic [4*DATA_W-1:0]   req_data,
    output logic [3:0]            req_ready,
    input  logic                  wr_stall,
    output logic                  wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [DATA_W-1:0]     wr_data,
    output logic [1:0]            wr_src
);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [1:0]          r_ptr;
    logic [1:0]          w_ptr_nxt;

    logic                w_open;
    logic                w_gnt_any;
    logic [1:0]          w_gnt_idx;
    logic                w_accept;
    logic                w_present;
    logic                w_load;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_data;

    logic [ADDR_W-1:0]   r_wr_addr_p1;
    logic [DATA_W-1:0]   r_wr_data_p1;
    logic [1:0]          r_wr_src_p1;

    // Returns {found, index}: first valid requester at ptr, ptr+1, ... (mod 4).
    function automatic logic [2:0] rr_pick(input logic [3:0] valid, input logic [1:0] ptr);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        // Walk offsets from farthest to nearest so the nearest valid one wins.
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (valid[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    always_comb begin
        w_open                 = (r_state == IDLE) || !wr_stall;
        {w_gnt_any, w_gnt_idx} = rr_pick(req_valid, r_ptr);
        // Qualified by reset so the handshake drops the instant reset asserts.
        w_accept               = w_open && w_gnt_any && reset;
        req_ready              = w_accept ? (4'b0001 << w_gnt_idx) : 4'b0000;
        w_sel_addr             = req_addr[w_gnt_idx*ADDR_W +: ADDR_W];
        w_sel_data             = req_data[w_gnt_idx*DATA_W +: DATA_W];
`ifdef REG_WR_ARB_ZERO_PROTECT_EN
        w_present              = w_accept && (w_sel_addr != '0);
`else
        w_present              = w_accept;
`endif
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_load      = 1'b0;
        if (w_accept) begin
            w_ptr_nxt = w_gnt_idx + 2'd1;
        end
        if (w_present) begin
            w_state_nxt = ISSUE;
            w_load      = 1'b1;
        end else if ((r_state == ISSUE) && !wr_stall) begin
            // A swallowed address-0 transfer also lands here, so a completed write is never replayed.
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_ptr   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Stage p1: write presented to the register file, held while stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_addr_p1 <= '0;
            r_wr_data_p1 <= '0;
            r_wr_src_p1  <= 2'd0;
        end else if (w_load) begin
            r_wr_addr_p1 <= w_sel_addr;
            r_wr_data_p1 <= w_sel_data;
            r_wr_src_p1  <= w_gnt_idx;
        end
    end

    assign wr_en   = (r_state == ISSUE);
    assign wr_addr = r_wr_addr_p1;
    assign wr_data = r_wr_data_p1;
    assign wr_src  = r_wr_src_p1;

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Self-checking bench for reg_wr_arbiter: directed scenarios plus randomized traffic against a queue-free reference model.
module tb_reg_wr_arbiter;
    localparam int AW = 4;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [3:0]      req_valid;
    logic [4*AW-1:0] req_addr;
    logic [4*DW-1:0] req_data;
    logic [3:0]      req_ready;
    logic            wr_stall;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic [1:0]      wr_src;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: pointer plus the one write currently presented.
    int            m_ptr;
    bit            m_pend;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    int            m_src;

    reg_wr_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ready(req_ready), .wr_stall(wr_stall),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_src(wr_src)
    );

    always #5 clk = ~clk;

    function automatic int exp_grant();
        if (m_pend && wr_stall) return -1;
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (m_ptr + k) % 4;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_ready();
        int g;
        g = exp_grant();
        if (g < 0) return 4'b0000;
        return 4'(1 << g);
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_pend = 0; m_addr = '0; m_data = '0; m_src = 0;
    endtask

    task automatic model_update();
        int g;
        bit zp;
        logic [AW-1:0] a;
`ifdef REG_WR_ARB_ZERO_PROTECT_EN
        zp = 1'b1;
`else
        zp = 1'b0;
`endif
        g = exp_grant();
        if (g >= 0) begin
            a = req_addr[g*AW +: AW];
            m_ptr = (g + 1) % 4;
            if (zp && a == '0) begin
                if (m_pend && !wr_stall) m_pend = 0;
            end else begin
                m_pend = 1;
                m_addr = a;
                m_data = req_data[g*DW +: DW];
                m_src  = g;
            end
        end else if (m_pend && !wr_stall) begin
            m_pend = 0;
        end
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    // Called at a falling edge: apply inputs and let combinational outputs settle.
    task automatic drive(input logic [3:0] v, input logic s);
        req_valid = v;
        wr_stall  = s;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        req_valid = 4'b0000;
        wr_stall  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        req_valid = 4'b1111;
        wr_stall  = 1'b0;
        model_reset();
        #1;
        n_checks++; if (req_ready !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", req_ready); else n_pass++;
        n_checks++; if ({wr_en, wr_addr, wr_data, wr_src} !== '0)
            $display("FAIL reset_outputs: got en=%b addr=%h data=%h src=%0d want all 0", wr_en, wr_addr, wr_data, wr_src);
        else n_pass++;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        set_req(2, 4'h7, 16'h0C0D);
        drive(4'b0100, 1'b0);
        n_checks++; if (req_ready !== 4'b0100) $display("FAIL first_edge_ready: got %b want 0100", req_ready); else n_pass++;
        tick();
        n_checks++; if (wr_en !== 1'b1 || wr_src !== 2'd2 || wr_addr !== 4'h7)
            $display("FAIL first_edge_write: got en=%b src=%0d addr=%h want 1/2/7", wr_en, wr_src, wr_addr);
        else n_pass++;
        drive(4'b0000, 1'b0);
        tick();
    endtask

    task automatic test_mid_reset();
        do_reset();
        set_req(0, 4'h3, 16'hA5A5);
        drive(4'b0001, 1'b0);
        tick();
        drive(4'b1111, 1'b1);
        n_checks++; if (wr_en !== 1'b1 || req_ready !== 4'b0000)
            $display("FAIL stall_before_reset: got en=%b ready=%b want 1/0000", wr_en, req_ready);
        else n_pass++;
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        n_checks++; if (wr_en !== 1'b0 || req_ready !== 4'b0000 || wr_addr !== 4'h0 || wr_data !== 16'h0)
            $display("FAIL async_reset: got en=%b ready=%b addr=%h data=%h want 0/0000/0/0", wr_en, req_ready, wr_addr, wr_data);
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        drive(4'b0000, 1'b0);
        tick();
        n_checks++; if (wr_en !== 1'b0) $display("FAIL no_replay: got en=%b want 0", wr_en); else n_pass++;
        drive(4'b1111, 1'b0);
        n_checks++; if (req_ready !== 4'b0001) $display("FAIL ptr_cleared: got %b want 0001", req_ready); else n_pass++;
        tick();
        drive(4'b0000, 1'b0);
        tick();
    endtask

    task automatic test_round_robin();
        logic [DW-1:0] d [4];
        do_reset();
        for (int i = 0; i < 4; i++) begin
            d[i] = 16'($urandom);
            set_req(i, AW'(i + 8), d[i]);
        end
        for (int c = 0; c < 4; c++) begin
            drive(4'b1111, 1'b0);
            n_checks++; if (req_ready !== 4'(1 << c) || req_ready !== exp_ready())
                $display("FAIL rr_ready[%0d]: got %b want %b", c, req_ready, 4'(1 << c));
            else n_pass++;
            tick();
            n_checks++; if (wr_en !== 1'b1 || wr_src !== 2'(c) || wr_addr !== AW'(c + 8) || wr_data !== d[c])
                $display("FAIL rr_write[%0d]: got en=%b src=%0d addr=%h data=%h want 1/%0d/%h/%h",
                         c, wr_en, wr_src, wr_addr, wr_data, c, c + 8, d[c]);
            else n_pass++;
        end
        drive(4'b0000, 1'b0);
        tick();
        n_checks++; if (wr_en !== 1'b0) $display("FAIL rr_drain: got en=%b want 0", wr_en); else n_pass++;
    endtask

    task automatic test_stall();
        do_reset();
        set_req(2, 4'h5, 16'hBEEF);
        drive(4'b0100, 1'b0);
        n_checks++; if (req_ready !== 4'b0100) $display("FAIL stall_grant: got %b want 0100", req_ready); else n_pass++;
        tick();
        for (int s = 0; s < 3; s++) begin
            drive(4'b1111, 1'b1);
            n_checks++; if (req_ready !== 4'b0000) $display("FAIL stall_ready[%0d]: got %b want 0000", s, req_ready); else n_pass++;
            n_checks++; if (wr_en !== 1'b1 || wr_addr !== 4'h5 || wr_data !== 16'hBEEF || wr_src !== 2'd2)
                $display("FAIL stall_hold[%0d]: got en=%b addr=%h data=%h src=%0d want 1/5/beef/2", s, wr_en, wr_addr, wr_data, wr_src);
            else n_pass++;
            tick();
        end
        drive(4'b0000, 1'b0);
        n_checks++; if (wr_en !== 1'b1 || wr_addr !== 4'h5 || wr_data !== 16'hBEEF || wr_src !== 2'd2)
            $display("FAIL stall_hold_last: got en=%b addr=%h data=%h src=%0d want 1/5/beef/2", wr_en, wr_addr, wr_data, wr_src);
        else n_pass++;
        tick();
        n_checks++; if (wr_en !== 1'b0) $display("FAIL stall_release: got en=%b want 0", wr_en); else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset();
        set_req(2, 4'h1, 16'h2222);
        drive(4'b0100, 1'b0);
        tick();
        set_req(0, 4'h2, 16'h0A0A);
        set_req(3, 4'h4, 16'h3B3B);
        drive(4'b1001, 1'b0);
        n_checks++; if (req_ready !== 4'b1000) $display("FAIL wrap_first: got %b want 1000", req_ready); else n_pass++;
        tick();
        n_checks++; if (wr_src !== 2'd3 || wr_data !== 16'h3B3B) $display("FAIL wrap_src3: got src=%0d data=%h want 3/3b3b", wr_src, wr_data); else n_pass++;
        drive(4'b1001, 1'b0);
        n_checks++; if (req_ready !== 4'b0001) $display("FAIL wrap_second: got %b want 0001", req_ready); else n_pass++;
        tick();
        n_checks++; if (wr_en !== 1'b1 || wr_src !== 2'd0 || wr_data !== 16'h0A0A)
            $display("FAIL wrap_src0: got en=%b src=%0d data=%h want 1/0/0a0a", wr_en, wr_src, wr_data);
        else n_pass++;
        drive(4'b0000, 1'b0);
        tick();
    endtask

    task automatic test_zero_addr();
        do_reset();
        set_req(1, 4'h0, 16'h1234);
        set_req(2, 4'h9, 16'h9999);
        drive(4'b0010, 1'b0);
        n_checks++; if (req_ready !== 4'b0010) $display("FAIL zero_ready: got %b want 0010", req_ready); else n_pass++;
        tick();
`ifdef REG_WR_ARB_ZERO_PROTECT_EN
        n_checks++; if (wr_en !== 1'b0 || wr_data !== 16'h0) $display("FAIL zero_blocked: got en=%b data=%h want 0/0000", wr_en, wr_data); else n_pass++;
`else
        n_checks++; if (wr_en !== 1'b1 || wr_addr !== 4'h0 || wr_data !== 16'h1234 || wr_src !== 2'd1)
            $display("FAIL zero_written: got en=%b addr=%h data=%h src=%0d want 1/0/1234/1", wr_en, wr_addr, wr_data, wr_src);
        else n_pass++;
`endif
        drive(4'b1111, 1'b0);
        n_checks++; if (req_ready !== 4'b0100) $display("FAIL zero_ptr_advance: got %b want 0100", req_ready); else n_pass++;
        tick();
        drive(4'b0000, 1'b0);
        tick();
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            d = 16'($urandom);
            set_req(0, AW'(c + 1), d);
            drive(4'b0001, 1'b0);
            n_checks++; if (req_ready !== 4'b0001) $display("FAIL b2b_ready[%0d]: got %b want 0001", c, req_ready); else n_pass++;
            tick();
            n_checks++; if (wr_en !== 1'b1 || wr_addr !== AW'(c + 1) || wr_data !== d || wr_src !== 2'd0)
                $display("FAIL b2b_write[%0d]: got en=%b addr=%h data=%h src=%0d want 1/%h/%h/0", c, wr_en, wr_addr, wr_data, wr_src, c + 1, d);
            else n_pass++;
        end
        drive(4'b0000, 1'b0);
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) begin
                set_req(i, ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom), 16'($urandom));
            end
            drive(4'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0));
            n_checks++; if (req_ready !== exp_ready()) $display("FAIL rand_ready[%0d]: got %b want %b", c, req_ready, exp_ready()); else n_pass++;
            tick();
            n_checks++; if (wr_en !== m_pend || wr_addr !== m_addr || wr_data !== m_data || wr_src !== 2'(m_src))
                $display("FAIL rand_write[%0d]: got en=%b addr=%h data=%h src=%0d want %b/%h/%h/%0d",
                         c, wr_en, wr_addr, wr_data, wr_src, m_pend, m_addr, m_data, m_src);
            else n_pass++;
        end
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = 4'b0000;
        req_addr  = '0;
        req_data  = '0;
        wr_stall  = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_mid_reset();
        test_round_robin();
        test_stall();
        test_wrap();
        test_zero_addr();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
